// File: rtl/bus_data_responder_if.sv
// Load/store bus between CPU initiator and data responder; busErr only with BUS_ALIGN_CHECK_EN.
// Initiator holds busReq until the one-cycle busReady strobe.
interface bus_data_responder_if;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [2:0]  busFunct3;
  logic [31:0] busRData;
  logic        busReady;
`ifdef BUS_ALIGN_CHECK_EN
  logic        busErr;
`endif

  modport master (
    output busReq, busWe, busAddr, busWData, busFunct3,
`ifdef BUS_ALIGN_CHECK_EN
    input  busErr,
`endif
    input  busRData, busReady
  );

  modport slave (
    input  busReq, busWe, busAddr, busWData, busFunct3,
`ifdef BUS_ALIGN_CHECK_EN
    output busErr,
`endif
    output busRData, busReady
  );
endinterface

// File: rtl/bus_data_responder.sv
// Data-bus responder with word RAM; busReady WAIT_CYCLES+1 cycles after accept, busReq ignored until back in IDLE.
// Byte/half/word lanes on stores, sign/zero extension on loads; BUS_ALIGN_CHECK_EN adds the busErr check.
module bus_data_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bus_data_responder_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WLAST = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [2:0]  lat_f3;
  logic [31:0] rdata_q;
  logic [31:0] mem [DEPTH];

  logic                  cur_we;
  logic [31:0]           cur_addr, cur_wdata;
  logic [2:0]            cur_f3;
  logic                  in_win, acc_err, go_resp, wr_en;
  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]            lane;
  logic [31:0]           word, shifted, ld_val, wd_rep;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic [3:0]            be;

  // With zero wait states the accept edge is also the response edge, so decode the live inputs in IDLE.
  always_comb begin
    cur_we    = (state == S_IDLE) ? bus.busWe     : lat_we;
    cur_addr  = (state == S_IDLE) ? bus.busAddr   : lat_addr;
    cur_wdata = (state == S_IDLE) ? bus.busWData  : lat_wdata;
    cur_f3    = (state == S_IDLE) ? bus.busFunct3 : lat_f3;
  end

  assign in_win = (cur_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign widx   = cur_addr[ADDR_WIDTH+1:2];
  assign lane   = cur_addr[1:0];
  assign word   = mem[widx];

`ifdef BUS_ALIGN_CHECK_EN
  logic f3_ok, misal, err_q;

  always_comb begin
    f3_ok   = cur_we ? (cur_f3 inside {3'b000, 3'b001, 3'b010})
                     : (cur_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal   = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
              ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    acc_err = !f3_ok || misal || !in_win;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     err_q <= 1'b0;
    else if (go_resp) err_q <= acc_err;
  end

  assign bus.busErr = (state == S_RESP) && err_q;
`else
  assign acc_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.busReq) begin
          cnt_nxt   = '0;
          state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == WLAST) state_nxt = S_RESP;
        else              cnt_nxt   = cnt + 4'd1;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign go_resp = (state_nxt == S_RESP) && (state != S_RESP);

  always_comb begin
    shifted = word >> {lane, 3'b000};
    rbyte   = shifted[7:0];
    rhalf   = cur_addr[1] ? word[31:16] : word[15:0];
    ld_val  = '0;
    if (in_win && !acc_err) begin
      case (cur_f3)
        3'b000:  ld_val = {{24{rbyte[7]}}, rbyte};
        3'b001:  ld_val = {{16{rhalf[15]}}, rhalf};
        3'b010:  ld_val = word;
        3'b100:  ld_val = {24'h0, rbyte};
        3'b101:  ld_val = {16'h0, rhalf};
        default: ld_val = '0;
      endcase
    end
  end

  always_comb begin
    be     = '0;
    wd_rep = cur_wdata;
    case (cur_f3)
      3'b000: begin
        be     = 4'b0001 << lane;
        wd_rep = {4{cur_wdata[7:0]}};
      end
      3'b001: begin
        be     = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{cur_wdata[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = '0;
    endcase
    if (!in_win) be = '0;
  end

  // Reset gates the commit so an aborted zero-wait accept cannot write.
  assign wr_en = go_resp && cur_we && !acc_err && reset_n;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wd_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_f3    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && bus.busReq) begin
        lat_we    <= bus.busWe;
        lat_addr  <= bus.busAddr;
        lat_wdata <= bus.busWData;
        lat_f3    <= bus.busFunct3;
      end
      if (go_resp && !cur_we) rdata_q <= ld_val;
    end
  end

  assign bus.busReady = (state == S_RESP);
  assign bus.busRData = rdata_q;

endmodule
